// File: rtl/au_share_arbiter.sv
// au_share_arbiter: round-robin sharing of one combinational adder/subtractor between two requesters.
// Define AU_STATS_EN to add the saturating per-requester accept counters stat0_cnt/stat1_cnt.
module au_share_arbiter #(
    parameter int WIDTH  = 3,
    parameter int AU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_sub,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_sum,
    output logic             rsp0_carry,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_sub,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_sum,
    output logic             rsp1_carry,
    output logic [WIDTH-1:0] au_a,
    output logic [WIDTH-1:0] au_b,
    output logic             au_sub,
    input  logic [WIDTH-1:0] au_sum,
    input  logic             au_carry
`ifdef AU_STATS_EN
    ,
    output logic [7:0]       stat0_cnt,
    output logic [7:0]       stat1_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(AU_LAT - 1);

    state_t     state_r;
    state_t     state_nxt_s;
    logic       ptr_r;
    logic       owner_r;
    logic [3:0] cnt_r;
    logic       grant_s;
    logic       accept_s;
    logic       capture_s;

    // Arbitration and next-state decode; grant only matters in IDLE
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        accept_s    = 1'b0;
        capture_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_s = ptr_r;
                end else if (req1_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                if (req0_valid || req1_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign req0_ready = accept_s & ~grant_s;
    assign req1_ready = accept_s & grant_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch, owner, settle counter and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            au_a    <= {WIDTH{1'b0}};
            au_b    <= {WIDTH{1'b0}};
            au_sub  <= 1'b0;
            owner_r <= 1'b0;
            cnt_r   <= 4'd0;
            ptr_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                au_a    <= grant_s ? req1_a : req0_a;
                au_b    <= grant_s ? req1_b : req0_b;
                au_sub  <= grant_s ? req1_sub : req0_sub;
                owner_r <= grant_s;
                cnt_r   <= CNT_INIT;
            end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
                cnt_r <= cnt_r - 4'd1;
            end
            if (state_r == ST_DONE) begin
                ptr_r <= ~owner_r;
            end
        end
    end

    // Result capture; the valid pulse lands in the DONE cycle, sums hold until overwritten
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid <= 1'b0;
            rsp0_sum   <= {WIDTH{1'b0}};
            rsp0_carry <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_sum   <= {WIDTH{1'b0}};
            rsp1_carry <= 1'b0;
        end else begin
            rsp0_valid <= capture_s & ~owner_r;
            rsp1_valid <= capture_s & owner_r;
            if (capture_s && !owner_r) begin
                rsp0_sum   <= au_sum;
                rsp0_carry <= au_carry;
            end
            if (capture_s && owner_r) begin
                rsp1_sum   <= au_sum;
                rsp1_carry <= au_carry;
            end
        end
    end

`ifdef AU_STATS_EN
    // Saturating accept counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0_cnt <= 8'd0;
            stat1_cnt <= 8'd0;
        end else begin
            if (req0_ready && stat0_cnt != 8'hFF) begin
                stat0_cnt <= stat0_cnt + 8'd1;
            end
            if (req1_ready && stat1_cnt != 8'hFF) begin
                stat1_cnt <= stat1_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
